// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, PC-1/PC-2 and rotation helpers, schedule state type
package des_pkg;

    localparam logic [15:0] DES_SHIFT_MASK = 16'h7EFC;
    localparam int SUBKEY_W = 48;
    localparam int HALF_W = 28;

    typedef enum logic {KS_IDLE, KS_EMIT} ks_state_t;

    // Entries are 1-based DES bit numbers, bit 1 being the MSB of the source word.
    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1_T[i]];
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
        for (int i = 0; i < SUBKEY_W; i++) pc2[SUBKEY_W-1-i] = cd[56-PC2_T[i]];
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int n);
        logic [2*HALF_W-1:0] t;
        t = {x, x} << n;
        return t[2*HALF_W-1:HALF_W];
    endfunction

    // Net left rotation after n rounds; decrypt starts from C_n/D_n, which is C0/D0 for 16 rounds.
    function automatic int pre_shift(input logic [15:0] m, input int n);
        int s;
        s = 0;
        for (int r = 0; r < n; r++) s += 1 + int'(m[r]);
        return s % HALF_W;
    endfunction

endpackage

// File: rtl/des_key_schedule_seq_if.sv
// des_key_schedule_seq_if: key load command plus valid/ready subkey stream
//   master: drives key_in/start/decrypt/subkey_ready; slave: drives busy/subkey/subkey_valid/round_idx/last
interface des_key_schedule_seq_if #(parameter int ROUND_W = 4);
    logic [63:0] key_in;
    logic start;
    logic decrypt;
    logic busy;
    logic [47:0] subkey;
    logic subkey_valid;
    logic subkey_ready;
    logic [ROUND_W-1:0] round_idx;
    logic last;
    modport master (output key_in, start, decrypt, subkey_ready,
                    input busy, subkey, subkey_valid, round_idx, last);
    modport slave (input key_in, start, decrypt, subkey_ready,
                   output busy, subkey, subkey_valid, round_idx, last);
endinterface

// File: rtl/des_cd_rotator.sv
// des_cd_rotator: 28-bit circular rotate by 0/1/2; in_i/amt_i/dir_i (0 left, 1 right) -> out_o
import des_pkg::*;
module des_cd_rotator (
    input  logic [HALF_W-1:0] in_i,
    input  logic [1:0]        amt_i,
    input  logic              dir_i,
    output logic [HALF_W-1:0] out_o
);
    always_comb
        out_o = dir_i ? (amt_i == 2'd2 ? {in_i[1:0], in_i[HALF_W-1:2]} :
                         amt_i == 2'd1 ? {in_i[0], in_i[HALF_W-1:1]} : in_i)
                      : (amt_i == 2'd2 ? {in_i[HALF_W-3:0], in_i[HALF_W-1:HALF_W-2]} :
                         amt_i == 2'd1 ? {in_i[HALF_W-2:0], in_i[HALF_W-1]} : in_i);
endmodule

// File: rtl/des_key_schedule_seq.sv
// des_key_schedule_seq: sequential DES key schedule, one PC-2 subkey per accepted stream beat
//   clk/rst: clock, async active-high reset; ks: slave side of des_key_schedule_seq_if
import des_pkg::*;
module des_key_schedule_seq #(
    parameter int          NUM_ROUNDS = 16,
    parameter logic [15:0] SHIFT_MASK = DES_SHIFT_MASK,
    parameter int          ROUND_W    = 4
) (
    input logic clk,
    input logic rst,
    des_key_schedule_seq_if.slave ks
);
    localparam int DEC_PRE = pre_shift(SHIFT_MASK, NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

    ks_state_t state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d, c_src, d_src, c_rot, d_rot;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic dec_q, dec_d, emit, last, mbit, dir;
    logic [1:0] amt;
    logic [55:0] pk;

    assign pk = pc1(ks.key_in);
    assign emit = state_q == KS_EMIT;
    assign last = emit && idx_q == LAST_IDX;
    assign dir = emit ? dec_q : ks.decrypt;
    // Shift-mask bit for the rotation that produces the next beat (encrypt walks up, decrypt walks down).
    assign mbit = !emit ? SHIFT_MASK[0] :
                  SHIFT_MASK[dec_q ? 4'(NUM_ROUNDS - 1 - int'(idx_q)) : 4'(int'(idx_q) + 1)];
    assign amt = (!emit && ks.decrypt) ? 2'd0 : {mbit, ~mbit};
    assign c_src = emit ? c_q : ks.decrypt ? rotl28(pk[55:28], DEC_PRE) : pk[55:28];
    assign d_src = emit ? d_q : ks.decrypt ? rotl28(pk[27:0], DEC_PRE) : pk[27:0];

    des_cd_rotator u_rot_c (.in_i(c_src), .amt_i(amt), .dir_i(dir), .out_o(c_rot));
    des_cd_rotator u_rot_d (.in_i(d_src), .amt_i(amt), .dir_i(dir), .out_o(d_rot));

    always_comb begin
        state_d = state_q;
        c_d = c_q;
        d_d = d_q;
        idx_d = idx_q;
        dec_d = dec_q;
        if (!emit && ks.start) begin
            state_d = KS_EMIT;
            dec_d = ks.decrypt;
            c_d = c_rot;
            d_d = d_rot;
            idx_d = '0;
        end else if (emit && ks.subkey_ready) begin
            state_d = last ? KS_IDLE : KS_EMIT;
            c_d = last ? c_q : c_rot;
            d_d = last ? d_q : d_rot;
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= KS_IDLE;
            c_q <= '0;
            d_q <= '0;
            idx_q <= '0;
            dec_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q <= c_d;
            d_q <= d_d;
            idx_q <= idx_d;
            dec_q <= dec_d;
        end
    end

    assign ks.busy = emit;
    assign ks.subkey_valid = emit;
    assign ks.round_idx = idx_q;
    assign ks.last = last;
    assign ks.subkey = emit ? pc2({c_q, d_q}) : '0;
endmodule

// File: tb/tb_des_key_schedule_seq.sv
// tb_des_key_schedule_seq: scoreboard bench for 16-round and 4-round key schedule instances
import des_pkg::*;
module tb_des_key_schedule_seq;
    localparam logic [15:0] SM = 16'h7EFC;
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [47:0] K1 = 48'h1B02EFFC7072;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [47:0] sk;
        logic [3:0] idx;
        logic last;
    } beat_t;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, dec = 1'b0, ready = 1'b1, sel = 1'b0, rnd = 1'b0;
    logic [63:0] key = '0;
    logic v, lst, bsy, pv = 1'b0, pr = 1'b1;
    logic [47:0] sk, psk = '0;
    logic [3:0] idx, pidx = '0;
    beat_t sbq[$];
    beat_t eb;
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    des_key_schedule_seq_if #(.ROUND_W(4)) if0 ();
    des_key_schedule_seq_if #(.ROUND_W(2)) if1 ();
    des_key_schedule_seq #(.NUM_ROUNDS(16), .ROUND_W(4)) dut0 (.clk(clk), .rst(rst), .ks(if0));
    des_key_schedule_seq #(.NUM_ROUNDS(4), .ROUND_W(2)) dut1 (.clk(clk), .rst(rst), .ks(if1));

    assign if0.key_in = key;
    assign if1.key_in = key;
    assign if0.decrypt = dec;
    assign if1.decrypt = dec;
    assign if0.start = start & ~sel;
    assign if1.start = start & sel;
    assign if0.subkey_ready = ready;
    assign if1.subkey_ready = ready;
    assign v = sel ? if1.subkey_valid : if0.subkey_valid;
    assign lst = sel ? if1.last : if0.last;
    assign bsy = sel ? if1.busy : if0.busy;
    assign sk = sel ? if1.subkey : if0.subkey;
    assign idx = sel ? 4'(if1.round_idx) : if0.round_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference subkey for 1-based round r from cumulative rotation of C0/D0.
    function automatic logic [47:0] kexp(input logic [63:0] k, input int r);
        logic [55:0] p, cc, dd;
        int s;
        p = pc1(k);
        s = 0;
        for (int i = 0; i < r; i++) s += 1 + int'(SM[i]);
        s = s % 28;
        cc = {p[55:28], p[55:28]} << s;
        dd = {p[27:0], p[27:0]} << s;
        return pc2({cc[55:28], dd[55:28]});
    endfunction

    always @(negedge clk) begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst && pv && !pr) begin
            check("hold_valid", v, 1);
            check("hold_subkey", sk, psk);
            check("hold_idx", idx, pidx);
        end
        if (!rst && v && ready) begin
            if (sbq.size() == 0) check("unexpected_beat", idx, 64'hFFFF);
            else begin
                eb = sbq.pop_front();
                check("subkey", sk, eb.sk);
                check("round_idx", idx, eb.idx);
                check("last", lst, eb.last);
            end
        end
        pv = v;
        pr = ready;
        psk = sk;
        pidx = idx;
    end

    task automatic push_exp(input logic [63:0] k, input logic d, input int n);
        beat_t b;
        for (int j = 1; j <= n; j++) begin
            b.sk = kexp(k, d ? n + 1 - j : j);
            b.idx = 4'(j - 1);
            b.last = j == n;
            sbq.push_back(b);
        end
    endtask

    task automatic run(input logic [63:0] k, input logic d, input int n, input bit inj, input bit hold_last);
        bit chk_last;
        chk_last = k == KEY && n == 16;
        sel = n == 4;
        key = k;
        dec = d;
        push_exp(k, d, n);
        check("idle_busy", bsy, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        key = ~k;
        dec = ~d;
        check("lat_valid", v, 1);
        check("lat_busy", bsy, 1);
        if (chk_last) check("first_const", sk, d ? K16 : K1);
        for (int c = 0; c < 400 && sbq.size() != 0; c++) begin
            if (chk_last && lst) begin
                check("last_const", sk, d ? K1 : K16);
                chk_last = 0;
            end
            start = (inj && idx == 4'd5) || (hold_last && lst);
            @(posedge clk);
            #1;
        end
        check("drained", sbq.size(), 0);
        check("busy_fall", bsy, 0);
        check("valid_fall", v, 0);
        check("idx_clear", idx, 0);
        start = 1'b0;
        sbq.delete();
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_busy", bsy, 0);
        check("rst_valid", v, 0);
        check("rst_last", lst, 0);
        check("rst_idx", idx, 0);
        check("rst_subkey", sk, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run(KEY, 1'b0, 16, 0, 0);
        run(KEY, 1'b1, 16, 0, 1);
        rnd = 1'b1;
        run(KEY, 1'b0, 16, 1, 0);
        run(KEY2, 1'b1, 16, 0, 0);
        run(KEY2, 1'b0, 16, 1, 1);
        rnd = 1'b0;
        sel = 1'b0;
        key = KEY;
        dec = 1'b1;
        push_exp(KEY, 1'b1, 16);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 100 && idx != 4'd7; c++) begin
            @(posedge clk);
            #1;
        end
        check("reach_beat7", idx, 7);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", bsy, 0);
        check("mid_rst_valid", v, 0);
        check("mid_rst_last", lst, 0);
        check("mid_rst_idx", idx, 0);
        check("mid_rst_subkey", sk, 0);
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        run(KEY, 1'b0, 16, 0, 0);
        run(KEY, 1'b0, 4, 0, 0);
        run(KEY, 1'b1, 4, 0, 1);
        rnd = 1'b1;
        run(KEY2, 1'b1, 4, 0, 0);
        rnd = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
